ddr4_cmd_driver: RTL

- Controller-side command issuer for one DDR4 rank. It drives the RCD-output-style command/address bus (act_n, addr, ba, bg, par, cke, odt, cs_n, reset_n) that the rank simulation model consumes.
- Runs the power-up sequence (reset_n hold, then CKE low hold), then accepts single commands over a valid/ready handshake.
- Issues each command for one cycle and enforces a per-command minimum gap before the next command.
- Sits in the sim/traffic layer in front of the rdimm wrapper; used as a lightweight stimulus master.

---
 rtl/ddr4_cmd_pkg.sv | 46 ++++
 rtl/ddr4_cmd_timer.sv | 24 ++
 rtl/ddr4_cmd_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ddr4_cmd_pkg.sv
// Shared types and encodings for the DDR4 command driver.
// Holds command codes, FSM states, RAS/CAS/WE field values and the C/A parity helper.
package ddr4_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6
  } cmd_code_e;

  typedef enum logic [1:0] {
    S_RST_HOLD,
    S_CKE_WAIT,
    S_IDLE
  } state_e;

  // A16/A15/A14 (RAS/CAS/WE) for non-ACT commands
  localparam logic [2:0] RCW_MRS = 3'b000;
  localparam logic [2:0] RCW_REF = 3'b001;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_RD  = 3'b101;

  function automatic logic [2:0] rcw_of(input cmd_code_e c);
    case (c)
      CMD_REF: return RCW_REF;
      CMD_PRE: return RCW_PRE;
      CMD_WR:  return RCW_WR;
      CMD_RD:  return RCW_RD;
      default: return RCW_MRS;
    endcase
  endfunction

  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr4_cmd_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Used for the init holds, the inter-command gap and the ODT window.
module ddr4_cmd_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)              r_cnt <= RST_VAL;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ddr4_cmd_driver.sv
// Single-rank DDR4 command issuer: power-up sequencing, then one command per
// handshake, driven for one cycle with a per-command minimum gap before the next.
module ddr4_cmd_driver
  import ddr4_cmd_pkg::*;
#(
  parameter int MC_ABITS      = 18,
  parameter int MC_BANK_WIDTH = 2,
  parameter int MC_BANK_GROUP = 2,
  parameter int T_RESET       = 200,
  parameter int T_CKE         = 500,
  parameter int T_RCD         = 12,
  parameter int T_RP          = 12,
  parameter int T_RFC         = 280,
  parameter int T_MOD         = 24,
  parameter int T_CCD         = 4,
  parameter int ODT_LEN       = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [2:0]               i_cmd_code,
  input  logic [MC_ABITS-1:0]      i_cmd_addr,
  input  logic [MC_BANK_WIDTH-1:0] i_cmd_ba,
  input  logic [MC_BANK_GROUP-1:0] i_cmd_bg,
  output logic                     o_init_done,
  output logic                     o_reset_n,
  output logic                     o_cke,
  output logic                     o_cs_n,
  output logic                     o_act_n,
  output logic [MC_ABITS-1:0]      o_addr,
  output logic [MC_BANK_WIDTH-1:0] o_ba,
  output logic [MC_BANK_GROUP-1:0] o_bg,
  output logic                     o_par,
  output logic                     o_odt
);

  localparam int TMAX = imax(imax(imax(T_RESET, T_CKE), imax(T_RCD, T_RP)),
                             imax(imax(T_RFC, T_MOD), imax(T_CCD, ODT_LEN)));
  localparam int CW   = $clog2(TMAX + 1);

  if (T_RESET < 1 || T_CKE < 1 || T_RCD < 1 || T_RP < 1 || T_RFC < 1 ||
      T_MOD < 1 || T_CCD < 1 || ODT_LEN < 1) begin : g_bad_timing
    $error("ddr4_cmd_driver: every T_* and ODT_LEN must be >= 1");
  end
  if (MC_ABITS < 17 || MC_ABITS + MC_BANK_WIDTH + MC_BANK_GROUP + 1 > 64) begin : g_bad_width
    $error("ddr4_cmd_driver: MC_ABITS must cover A16 and the C/A word must fit 64 bits");
  end

  state_e                   r_state, w_state_nxt;
  logic                     r_reset_n, r_cke, r_init_done, r_cs_n, r_act_n, r_par;
  logic [MC_ABITS-1:0]      r_addr;
  logic [MC_BANK_WIDTH-1:0] r_ba;
  logic [MC_BANK_GROUP-1:0] r_bg;

  logic          w_init_zero, w_wait_zero, w_odt_zero;
  logic          w_init_load, w_is_cmd, w_issue, w_odt_load;
  logic [CW-1:0] w_gap;
  logic                w_act_n;
  logic [MC_ABITS-1:0] w_addr;
  cmd_code_e           w_code;

  assign w_code = cmd_code_e'(i_cmd_code);

  always_comb begin
    w_state_nxt = r_state;
    w_init_load = 1'b0;
    w_issue     = 1'b0;
    w_is_cmd    = 1'b1;
    w_gap       = '0;
    w_act_n     = 1'b1;
    w_addr      = i_cmd_addr;
    case (w_code)
      CMD_ACT:        begin w_act_n = 1'b0; w_gap = CW'(T_RCD - 1); end
      CMD_RD, CMD_WR: w_gap = CW'(T_CCD - 1);
      CMD_PRE:        w_gap = CW'(T_RP - 1);
      CMD_REF:        w_gap = CW'(T_RFC - 1);
      CMD_MRS:        w_gap = CW'(T_MOD - 1);
      default:        w_is_cmd = 1'b0;
    endcase
    if (w_code != CMD_ACT) w_addr[16:14] = rcw_of(w_code);
    case (r_state)
      S_RST_HOLD: if (w_init_zero) begin
        w_state_nxt = S_CKE_WAIT;
        w_init_load = 1'b1;
      end
      S_CKE_WAIT: if (w_init_zero) w_state_nxt = S_IDLE;
      S_IDLE:     w_issue = i_cmd_valid & w_wait_zero & w_is_cmd;
      default:    w_state_nxt = S_RST_HOLD;
    endcase
  end

  assign w_odt_load = w_issue && (w_code == CMD_WR);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_RST_HOLD;
    else       r_state <= w_state_nxt;
  end

  // Bus fields only change on issue, so deselect cycles hold the last command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reset_n   <= 1'b0;
      r_cke       <= 1'b0;
      r_init_done <= 1'b0;
      r_cs_n      <= 1'b1;
      r_act_n     <= 1'b1;
      r_addr      <= '0;
      r_ba        <= '0;
      r_bg        <= '0;
      r_par       <= 1'b0;
    end else begin
      r_cs_n <= ~w_issue;
      if (r_state == S_RST_HOLD && w_init_zero) r_reset_n <= 1'b1;
      if (r_state == S_CKE_WAIT && w_init_zero) begin
        r_cke       <= 1'b1;
        r_init_done <= 1'b1;
      end
      if (w_issue) begin
        r_act_n <= w_act_n;
        r_addr  <= w_addr;
        r_ba    <= i_cmd_ba;
        r_bg    <= i_cmd_bg;
        r_par   <= even_par(64'({w_act_n, w_addr, i_cmd_ba, i_cmd_bg}));
      end
    end
  end

  ddr4_cmd_timer #(.W(CW), .RST_VAL(CW'(T_RESET - 1))) u_init_tmr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_init_load),
    .i_val (CW'(T_CKE - 1)),
    .o_zero(w_init_zero)
  );

  ddr4_cmd_timer #(.W(CW)) u_wait_tmr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_issue),
    .i_val (w_gap),
    .o_zero(w_wait_zero)
  );

  ddr4_cmd_timer #(.W(CW)) u_odt_tmr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(w_odt_load),
    .i_val (CW'(ODT_LEN)),
    .o_zero(w_odt_zero)
  );

  assign o_cmd_ready = (r_state == S_IDLE) && w_wait_zero;
  assign o_init_done = r_init_done;
  assign o_reset_n   = r_reset_n;
  assign o_cke       = r_cke;
  assign o_cs_n      = r_cs_n;
  assign o_act_n     = r_act_n;
  assign o_addr      = r_addr;
  assign o_ba        = r_ba;
  assign o_bg        = r_bg;
  assign o_par       = r_par;
  assign o_odt       = ~w_odt_zero;

endmodule
